// File: rtl/qbus_arb_if.sv
// ============================================================================
// qbus_arb_if : Q-bus arbiter request/grant/refresh signal bundle
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface qbus_arb_if;
    logic [3:0] dmr;
    logic [3:0] sack;
    logic       cpu_sync;
    logic       cpu_rply;
    logic [3:0] dmg;
    logic       cpu_hold;
    logic       dref;
    logic       gto_err;
    logic       rf_miss;

    // master: the arbiter itself; slave: the bus side (masters, CPU, DRAM)
    modport master (
        input  dmr, sack, cpu_sync, cpu_rply,
        output dmg, cpu_hold, dref, gto_err, rf_miss
    );

    modport slave (
        output dmr, sack, cpu_sync, cpu_rply,
        input  dmg, cpu_hold, dref, gto_err, rf_miss
    );
endinterface

`default_nettype wire

// File: rtl/qbus_arb.sv
// ============================================================================
// qbus_arb : fixed-priority Q-bus DMA arbiter with DRAM refresh scheduling
// Revision : 1.0
// ============================================================================
`default_nettype none

module qbus_arb #(
    parameter int RF_PERIOD = 64,
    parameter int RF_LEN    = 4,
    parameter int GTO       = 15
) (
    input  wire logic       pin_clk,
    input  wire logic       pin_rst,
    qbus_arb_if.master      bus
);

    localparam int RW = (RF_PERIOD > 1) ? $clog2(RF_PERIOD) : 1;

    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_GRANT    = 2'd1;
    localparam logic [1:0]    c_OWN      = 2'd2;
    localparam logic [1:0]    c_RFSH     = 2'd3;
    localparam logic [RW-1:0] c_RF_LAST  = RW'(RF_PERIOD - 1);
    localparam logic [5:0]    c_GTO_LAST = 6'(GTO - 1);
    localparam logic [3:0]    c_LEN_LAST = 4'(RF_LEN - 1);

    logic [1:0]    r_state,   w_state_nx;
    logic [RW-1:0] r_rf_cnt;
    logic          r_rf_pend;
    logic [1:0]    r_idx,     w_idx_nx;
    logic [5:0]    r_gto_cnt, w_gto_cnt_nx;
    logic [3:0]    r_len_cnt, w_len_cnt_nx;
    logic [3:0]    r_dmg,     w_dmg_nx;
    logic          r_cpu_hold;
    logic          r_dref,    w_dref_nx;
    logic          r_gto_err, w_gto_err_nx;
    logic          r_rf_miss;

    logic          w_bus_free;
    logic          w_rf_wrap;
    logic          w_rf_take;
    logic [1:0]    w_low_idx;

    assign w_bus_free = ~bus.cpu_sync & ~bus.cpu_rply & (bus.sack == 4'b0000);
    assign w_rf_wrap  = (r_rf_cnt == c_RF_LAST);

    always_comb begin
        w_low_idx = 2'd3;
        if      (bus.dmr[0]) w_low_idx = 2'd0;
        else if (bus.dmr[1]) w_low_idx = 2'd1;
        else if (bus.dmr[2]) w_low_idx = 2'd2;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_gto_cnt_nx = r_gto_cnt;
        w_len_cnt_nx = r_len_cnt;
        w_dmg_nx     = r_dmg;
        w_dref_nx    = r_dref;
        w_gto_err_nx = 1'b0;
        w_rf_take    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_dmg_nx  = 4'b0000;
                w_dref_nx = 1'b0;
                // a pending refresh beats every DMA request
                if (w_bus_free && r_rf_pend) begin
                    w_rf_take    = 1'b1;
                    w_state_nx   = c_RFSH;
                    w_dref_nx    = 1'b1;
                    w_len_cnt_nx = 4'd0;
                end else if (w_bus_free && (bus.dmr != 4'b0000)) begin
                    w_idx_nx     = w_low_idx;
                    w_state_nx   = c_GRANT;
                    w_dmg_nx     = 4'b0001 << w_low_idx;
                    w_gto_cnt_nx = 6'd0;
                end
            end
            c_GRANT: begin
                // acknowledge outranks both cancellation and timeout
                if (bus.sack[r_idx]) begin
                    w_state_nx = c_OWN;
                    w_dmg_nx   = 4'b0000;
                end else if (!bus.dmr[r_idx]) begin
                    w_state_nx = c_IDLE;
                    w_dmg_nx   = 4'b0000;
                end else if (r_gto_cnt == c_GTO_LAST) begin
                    w_state_nx   = c_IDLE;
                    w_dmg_nx     = 4'b0000;
                    w_gto_err_nx = 1'b1;
                end else begin
                    w_gto_cnt_nx = r_gto_cnt + 6'd1;
                end
            end
            c_OWN: begin
                if (!bus.sack[r_idx]) begin
                    w_state_nx = c_IDLE;
                end
            end
            default: begin
                if (r_len_cnt == c_LEN_LAST) begin
                    w_state_nx = c_IDLE;
                    w_dref_nx  = 1'b0;
                end else begin
                    w_len_cnt_nx = r_len_cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            r_state    <= c_IDLE;
            r_rf_cnt   <= '0;
            r_rf_pend  <= 1'b0;
            r_idx      <= 2'd0;
            r_gto_cnt  <= 6'd0;
            r_len_cnt  <= 4'd0;
            r_dmg      <= 4'b0000;
            r_cpu_hold <= 1'b0;
            r_dref     <= 1'b0;
            r_gto_err  <= 1'b0;
            r_rf_miss  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rf_cnt   <= w_rf_wrap ? '0 : r_rf_cnt + 1'b1;
            // a request taken on the wrap edge is serviced, so it is not a miss
            r_rf_pend  <= w_rf_wrap | (r_rf_pend & ~w_rf_take);
            r_rf_miss  <= w_rf_wrap & r_rf_pend & ~w_rf_take;
            r_idx      <= w_idx_nx;
            r_gto_cnt  <= w_gto_cnt_nx;
            r_len_cnt  <= w_len_cnt_nx;
            r_dmg      <= w_dmg_nx;
            r_cpu_hold <= (w_state_nx != c_IDLE);
            r_dref     <= w_dref_nx;
            r_gto_err  <= w_gto_err_nx;
        end
    end

    assign bus.dmg      = r_dmg;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.dref     = r_dref;
    assign bus.gto_err  = r_gto_err;
    assign bus.rf_miss  = r_rf_miss;

endmodule

`default_nettype wire
